// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial load/store responder between the MEM stage and a byte-wide RAM.
// Splits halfwords/words into little-endian byte accesses and extends load data.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [1:0]            len_in,
    input  logic                  signed_in,
    input  logic [31:0]           wdata_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [31:0]           rdata_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic                  ram_we_out,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_top;
    logic                  r_signed;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rbuf;

    logic [CNT_W-1:0]      w_cnt;
    logic [CNT_W-1:0]      w_top;
    logic [CNT_W-1:0]      w_len_top;
    logic                  w_signed;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_rbuf;
    logic [DATA_W-1:0]     w_rdata;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_dout;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_we;
    logic                  w_accept;
    logic                  w_last;

    // done_out gating keeps a request still held during the done cycle from re-issuing
    assign w_accept = (r_state == S_IDLE) && req_in && !done_out;
    assign w_last   = (r_cnt == r_top);

    // Index of the final byte: 0, 1 or 3
    always_comb begin
        w_len_top = CNT_W'(3);
        case (len_in)
            2'd0:    w_len_top = CNT_W'(0);
            2'd1:    w_len_top = CNT_W'(1);
            default: w_len_top = CNT_W'(3);
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = we_in ? S_WRITE : S_READ;
                end
            end
            S_READ, S_WRITE: begin
                if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and request context
    always_comb begin
        w_busy   = busy_out;
        w_done   = 1'b0;
        w_rdata  = rdata_out;
        w_addr   = ram_addr_out;
        w_we     = 1'b0;
        w_dout   = ram_dout;
        w_cnt    = r_cnt;
        w_top    = r_top;
        w_signed = r_signed;
        w_wdata  = r_wdata;
        w_rbuf   = r_rbuf;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_busy   = 1'b1;
                    w_addr   = addr_in;
                    w_we     = we_in;
                    w_dout   = we_in ? wdata_in[7:0] : ram_dout;
                    w_cnt    = '0;
                    w_top    = w_len_top;
                    w_signed = signed_in;
                    w_wdata  = wdata_in;
                    w_rbuf   = '0;
                end
            end
            S_READ: begin
                w_rbuf[{r_cnt, 3'b000} +: 8] = ram_din;
                if (w_last) begin
                    w_busy = 1'b0;
                    w_done = 1'b1;
                    case (r_top)
                        2'd0: w_rdata = r_signed ? {{24{w_rbuf[7]}}, w_rbuf[7:0]}
                                                 : {24'd0, w_rbuf[7:0]};
                        2'd1: w_rdata = r_signed ? {{16{w_rbuf[15]}}, w_rbuf[15:0]}
                                                 : {16'd0, w_rbuf[15:0]};
                        default: w_rdata = w_rbuf;
                    endcase
                end else begin
                    w_addr = ram_addr_out + ADDR_WIDTH'(1);
                    w_cnt  = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_busy = 1'b0;
                    w_done = 1'b1;
                end else begin
                    w_cnt  = r_cnt + CNT_W'(1);
                    w_addr = ram_addr_out + ADDR_WIDTH'(1);
                    w_we   = 1'b1;
                    w_dout = r_wdata[{w_cnt, 3'b000} +: 8];
                end
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            rdata_out    <= '0;
            ram_addr_out <= '0;
            ram_we_out   <= 1'b0;
            ram_dout     <= '0;
            r_cnt        <= '0;
            r_top        <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_rbuf       <= '0;
        end else begin
            busy_out     <= w_busy;
            done_out     <= w_done;
            rdata_out    <= w_rdata;
            ram_addr_out <= w_addr;
            ram_we_out   <= w_we;
            ram_dout     <= w_dout;
            r_cnt        <= w_cnt;
            r_top        <= w_top;
            r_signed     <= w_signed;
            r_wdata      <= w_wdata;
            r_rbuf       <= w_rbuf;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven load/store vectors plus reset-abort and back-to-back sequences.
module tb_mem_ctrl;

    localparam int unsigned AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          req_in = 1'b0;
    logic          we_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [1:0]    len_in = '0;
    logic          signed_in = 1'b0;
    logic [31:0]   wdata_in = '0;
    logic          busy_out;
    logic          done_out;
    logic [31:0]   rdata_out;
    logic [AW-1:0] ram_addr_out;
    logic          ram_we_out;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req_in       (req_in),
        .we_in        (we_in),
        .addr_in      (addr_in),
        .len_in       (len_in),
        .signed_in    (signed_in),
        .wdata_in     (wdata_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .rdata_out    (rdata_out),
        .ram_addr_out (ram_addr_out),
        .ram_we_out   (ram_we_out),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din)
    );

    always #5 clk_in = ~clk_in;

    // Read data for the current address is ready before the next rising edge
    logic [7:0] mem [0:1023];
    assign ram_din = mem[ram_addr_out[9:0]];

    logic [31:0] addr_q[$];
    logic        we_q[$];
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          done_cnt = 0;

    always @(negedge clk_in) begin
        if (busy_out) begin
            addr_q.push_back(ram_addr_out);
            we_q.push_back(ram_we_out);
        end
        if (ram_we_out) begin
            wa_q.push_back(ram_addr_out);
            wd_q.push_back(ram_dout);
        end
        if (done_out) done_cnt++;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 10;
    vec_t        vecs[NVEC];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_in    = 1'b1;
        we_in     = v.we;
        addr_in   = v.addr;
        len_in    = v.len;
        signed_in = v.sgn;
        wdata_in  = v.wdata;
    endtask

    // Wait for done_out with a cycle budget; returns cycles elapsed (budget+1 on timeout)
    task automatic wait_done(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 12) begin
            tick();
            cyc++;
            if (done_out) seen = 1'b1;
        end
        if (!seen) cyc = 13;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        int          a0;
        int          w0;
        int          cyc;
        logic [31:0] exp_r;
        logic [31:0] sh;
        n  = (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
        a0 = addr_q.size();
        w0 = wa_q.size();
        drive(v);
        wait_done(tag, cyc);
        chk({tag, " latency"}, 32'(cyc), 32'(n + 1));
        exp_r = v.we ? last_rdata : v.exp_rdata;
        chk({tag, " rdata"}, rdata_out, exp_r);
        last_rdata = exp_r;
        chk({tag, " busy_at_done"}, 32'(busy_out), 32'd0);
        chk({tag, " we_at_done"}, 32'(ram_we_out), 32'd0);
        chk({tag, " busy_cycles"}, 32'(addr_q.size() - a0), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (a0 + k < addr_q.size()) begin
                chk($sformatf("%s addr%0d", tag, k), addr_q[a0 + k], v.addr + 32'(k));
                chk($sformatf("%s we%0d", tag, k), 32'(we_q[a0 + k]), 32'(v.we));
            end
        end
        chk({tag, " write_count"}, 32'(wa_q.size() - w0), v.we ? 32'(n) : 32'd0);
        if (v.we) begin
            for (int k = 0; k < n; k++) begin
                if (w0 + k < wa_q.size()) begin
                    sh = v.wdata >> (8 * k);
                    chk($sformatf("%s waddr%0d", tag, k), wa_q[w0 + k], v.addr + 32'(k));
                    chk($sformatf("%s wbyte%0d", tag, k), 32'(wd_q[w0 + k]), 32'(sh[7:0]));
                end
            end
        end
        req_in = 1'b0;
        tick();
        chk({tag, " done_single"}, 32'(done_out), 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;
        int w0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        mem[10'h010] = 8'h80;
        mem[10'h020] = 8'h34; mem[10'h021] = 8'hF2;
        mem[10'h3FF] = 8'h5A; mem[10'h000] = 8'hC3;
        mem[10'h030] = 8'h01; mem[10'h031] = 8'h02; mem[10'h032] = 8'h03; mem[10'h033] = 8'h84;

        vecs[0] = '{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'h4433_2211};
        vecs[1] = '{1'b0, 32'h0000_0010, 2'd0, 1'b1, 32'h0, 32'hFFFF_FF80};
        vecs[2] = '{1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0, 32'h0000_0080};
        vecs[3] = '{1'b0, 32'h0000_0020, 2'd1, 1'b1, 32'h0, 32'hFFFF_F234};
        vecs[4] = '{1'b0, 32'h0000_0020, 2'd1, 1'b0, 32'h0, 32'h0000_F234};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, 32'h0, 32'hFFFF_C35A};
        vecs[6] = '{1'b0, 32'h0000_0030, 2'd3, 1'b1, 32'h0, 32'h8403_0201};
        vecs[7] = '{1'b1, 32'h0000_0200, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[8] = '{1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h1234_ABCD, 32'h0};
        vecs[9] = '{1'b1, 32'h0000_0205, 2'd0, 1'b1, 32'hFFFF_FF77, 32'h0};

        #2 rst_in = 1'b0;
        #1;
        chk("reset busy", 32'(busy_out), 32'd0);
        chk("reset done", 32'(done_out), 32'd0);
        chk("reset rdata", rdata_out, 32'd0);
        chk("reset ram_addr", ram_addr_out, 32'd0);
        chk("reset ram_we", 32'(ram_we_out), 32'd0);
        chk("reset ram_dout", 32'(ram_dout), 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Held request through the done cycle, then a new request right after
        d0 = done_cnt;
        drive(vecs[0]);
        wait_done("held", cyc);
        chk("held rdata", rdata_out, 32'h4433_2211);
        last_rdata = 32'h4433_2211;
        tick();
        chk("held no_reissue busy", 32'(busy_out), 32'd0);
        chk("held done_cleared", 32'(done_out), 32'd0);
        drive(vecs[3]);
        tick();
        chk("b2b busy", 32'(busy_out), 32'd1);
        chk("b2b first_addr", ram_addr_out, 32'h0000_0020);
        tick();
        chk("b2b second_addr", ram_addr_out, 32'h0000_0021);
        wait_done("b2b", cyc);
        chk("b2b latency_rest", 32'(cyc), 32'd1);
        chk("b2b rdata", rdata_out, 32'hFFFF_F234);
        last_rdata = 32'hFFFF_F234;
        req_in = 1'b0;
        tick();
        tick();
        chk("b2b done_count", 32'(done_cnt - d0), 32'd2);

        // Abort a word load after two bytes with an asynchronous reset
        d0 = done_cnt;
        w0 = wa_q.size();
        drive(vecs[0]);
        tick();
        chk("abort addr0", ram_addr_out, 32'h0000_0100);
        tick();
        chk("abort addr1", ram_addr_out, 32'h0000_0101);
        #2 rst_in = 1'b0;
        req_in = 1'b0;
        #1;
        chk("abort busy", 32'(busy_out), 32'd0);
        chk("abort done", 32'(done_out), 32'd0);
        chk("abort rdata", rdata_out, 32'd0);
        chk("abort ram_addr", ram_addr_out, 32'd0);
        chk("abort ram_we", 32'(ram_we_out), 32'd0);
        chk("abort ram_dout", 32'(ram_dout), 32'd0);
        last_rdata = 32'd0;
        tick();
        tick();
        #2 rst_in = 1'b1;
        tick();
        chk("abort no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort no_writes", 32'(wa_q.size() - w0), 32'd0);
        chk("abort idle_busy", 32'(busy_out), 32'd0);
        run_vec(vecs[0], "post_reset");
        run_vec(vecs[7], "post_reset_store");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory-side responder for the MEM stage's load/store requests. Serves one request at a time over a byte-wide synchronous RAM port. Splits each word or halfword into sequential little-endian byte accesses, reassembles and extends load data, and returns a one-cycle completion pulse. Sits between MEM and the on-chip RAM.

Parameters:
ADDR_WIDTH, 32, width of addr_in and ram_addr_out; all address arithmetic is modulo 2^ADDR_WIDTH

Ports:
clk_in  input  1  clock; all state changes on rising edge
rst_in  input  1  reset; asynchronous, active-low
req_in  input  1  request valid; requester holds it, with fields stable, until it sees done_out
we_in  input  1  1=store, 0=load
addr_in  input  ADDR_WIDTH  byte address; any alignment allowed
len_in  input  2  0=byte, 1=half, 2=word, 3=treated as word
signed_in  input  1  load only: 1=sign-extend, 0=zero-extend
wdata_in  input  32  store data; low n bytes used
busy_out  output  1  transaction in progress
done_out  output  1  one-cycle completion pulse
rdata_out  output  32  load result; valid while done_out=1, held until the next load completes
ram_addr_out  output  ADDR_WIDTH  RAM byte address
ram_we_out  output  1  RAM write enable
ram_dout  output  8  RAM write byte
ram_din  input  8  RAM read byte; data for the address driven in cycle N is valid in cycle N+1

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE. busy_out, done_out, rdata_out, ram_addr_out, ram_we_out and ram_dout all go to 0 immediately. Any in-flight transaction is aborted with no done_out pulse and no further RAM writes.
- Byte count n: 1, 2 or 4 from len_in (3 gives 4). All request fields are latched on the accepting edge; later input changes are ignored.
- States:
  - IDLE: accept when req_in=1 and done_out=0. Because the accepting check requires done_out=0, a held req_in is never re-issued in the done cycle. On accept go to READ or WRITE; busy_out=1.
  - READ: on the accepting edge E0, ram_addr_out=addr and ram_we_out=0. On edges E1..E(n-1), ram_addr_out=addr+k. On edge E(k+1), ram_din is captured as byte k. At edge En: rdata_out is loaded, done_out=1, busy_out=0, state goes to IDLE.
  - WRITE: on edge Ek (k=0..n-1), ram_addr_out=addr+k, ram_we_out=1, ram_dout=wdata[8k+7:8k]. At edge En: ram_we_out=0, done_out=1, busy_out=0, state goes to IDLE. rdata_out is unchanged.
- Timing: done_out is high for exactly the one cycle after edge En. It is never asserted for two consecutive cycles.
- Load assembly (little-endian): byte k goes to rdata[8k+7:8k].
  - Signed byte: bit 7 fills bits 31:8.
  - Signed half: bit 15 fills bits 31:16.
  - Unsigned: upper bits are zero.
  - Word: signed_in is ignored.
- Address wrap: addr+k wraps modulo 2^ADDR_WIDTH. For example, a half at all-ones then address 0.
- In IDLE, ram_we_out=0 and ram_addr_out/ram_dout hold their last values.
- The earliest next accept is the edge after the done cycle. In that case ram_addr_out changes without an idle gap.
- Reset deasserting mid-cycle is acted on at the first rising edge with rst_in=1.

Test Plan:
- Word load at 0x100, RAM bytes 11 22 33 44 -> ram_addr 0x100..0x103 on consecutive cycles; done_out one cycle after the 4th edge; rdata_out=0x44332211; busy_out high for 4 cycles.
- Byte and half loads:
  - Signed byte at byte 0x80 -> 0xFFFFFF80.
  - Unsigned byte at byte 0x80 -> 0x00000080.
  - Signed half, bytes 34 F2 -> 0xFFFFF234.
  - Unsigned half, same bytes -> 0x0000F234.
- Word store of 0xDEADBEEF at 0x200 -> ram_we_out=1 for exactly 4 cycles writing EF,BE,AD,DE to 0x200..0x203; then ram_we_out=0 with a done_out pulse; rdata_out unchanged.
- Half store of 0xABCD at 0xFFFFFFFF -> CD written to 0xFFFFFFFF, AB written to 0x00000000.
- Reset asserted after 2 bytes of a word load -> all outputs 0 asynchronously, no done_out; after release, a word load returns correct data.
- req_in held high through done_out -> exactly one transaction. A new request presented after done is accepted on the next edge, and RAM bytes are issued back-to-back.
